// File: rtl/sblk_row_inst_sched_if.sv
// Interface bundling the instruction stream handshake and the row array
// issue/status signals of sblk_row_inst_sched.
// The SBLK_SCHED_PERF_EN macro adds the per-row issue_cnt and stall_cnt buses.
// The master modport is the upstream source plus row array side; the slave
// modport is the scheduler.
interface sblk_row_inst_sched_if #(
  parameter int N_ROW    = 3,
  parameter int WID_INST = 14
);
  logic [WID_INST-1:0]       inst_in_data;
  logic [N_ROW-1:0]          inst_in_mask;
  logic                      inst_in_vld;
  logic                      inst_in_rdy;
  logic [N_ROW-1:0]          status_sblk;
  logic [WID_INST*N_ROW-1:0] inst_data;
  logic [N_ROW-1:0]          inst_en;
  logic                      sched_idle;
  logic                      err_zero_mask;
`ifdef SBLK_SCHED_PERF_EN
  logic [16*N_ROW-1:0]       issue_cnt;
  logic [16*N_ROW-1:0]       stall_cnt;

  modport master (
    output inst_in_data, inst_in_mask, inst_in_vld, status_sblk,
    input  inst_in_rdy, inst_data, inst_en, sched_idle, err_zero_mask,
           issue_cnt, stall_cnt
  );
  modport slave (
    input  inst_in_data, inst_in_mask, inst_in_vld, status_sblk,
    output inst_in_rdy, inst_data, inst_en, sched_idle, err_zero_mask,
           issue_cnt, stall_cnt
  );
`else
  modport master (
    output inst_in_data, inst_in_mask, inst_in_vld, status_sblk,
    input  inst_in_rdy, inst_data, inst_en, sched_idle, err_zero_mask
  );
  modport slave (
    input  inst_in_data, inst_in_mask, inst_in_vld, status_sblk,
    output inst_in_rdy, inst_data, inst_en, sched_idle, err_zero_mask
  );
`endif
endinterface

// File: rtl/sblk_row_inst_sched.sv
// Instruction scheduler in front of the superblock row array (low-speed clock).
// Buffers one instruction per row and issues it when the row reports idle,
// then holds the row in a guard window while status_sblk catches up.
// Optional macro SBLK_SCHED_PERF_EN adds per-row issue and stall counters.
module sblk_row_inst_sched #(
  parameter int N_ROW      = 3,
  parameter int WID_INST   = 14,
  parameter int STATUS_LAT = 2,
  parameter int WID_GUARD  = (STATUS_LAT > 0) ? $clog2(STATUS_LAT + 1) : 1
) (
  input  logic                 clk_l,
  input  logic                 rst,
  sblk_row_inst_sched_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PEND  = 2'd1,
    ISSUE = 2'd2,
    GUARD = 2'd3
  } row_state_e;

  localparam logic [WID_GUARD-1:0] GUARD_INIT =
    WID_GUARD'((STATUS_LAT > 0) ? STATUS_LAT - 1 : 0);

  row_state_e          state_q [N_ROW];
  row_state_e          state_d [N_ROW];
  logic [WID_GUARD-1:0] guard_q [N_ROW];
  logic [WID_GUARD-1:0] guard_d [N_ROW];
  logic [WID_INST-1:0]  hold_q  [N_ROW];
  logic [WID_INST-1:0]  data_q  [N_ROW];

  logic [N_ROW-1:0]          empty_vec;
  logic [N_ROW-1:0]          en_vec;
  logic [WID_INST*N_ROW-1:0] data_flat;
  logic                      accept;
  logic                      sched_idle_q;
  logic                      err_zero_mask_q;

  // Decode per-row status vectors and flatten the issue data bus.
  always_comb begin
    empty_vec = '0;
    en_vec    = '0;
    data_flat = '0;
    for (int r = 0; r < N_ROW; r++) begin
      empty_vec[r]                     = (state_q[r] == EMPTY);
      en_vec[r]                        = (state_q[r] == ISSUE);
      data_flat[r*WID_INST +: WID_INST] = data_q[r];
    end
  end

  // Ready depends only on state and the offered mask, so a broadcast loads
  // all of its rows in one edge or none of them.
  assign bus.inst_in_rdy   = ~rst & ((bus.inst_in_mask & ~empty_vec) == '0);
  assign accept            = bus.inst_in_vld & bus.inst_in_rdy;
  assign bus.inst_en       = en_vec;
  assign bus.inst_data     = data_flat;
  assign bus.sched_idle    = sched_idle_q;
  assign bus.err_zero_mask = err_zero_mask_q;

  // Next-state logic of the independent per-row FSMs.
  always_comb begin
    for (int r = 0; r < N_ROW; r++) begin
      // NOTE: every output gets a default before the case so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d[r] = state_q[r];
      guard_d[r] = guard_q[r];
      unique case (state_q[r])
        EMPTY: begin
          if (accept && bus.inst_in_mask[r]) state_d[r] = PEND;
        end
        PEND: begin
          if (!bus.status_sblk[r]) state_d[r] = ISSUE;
        end
        ISSUE: begin
          if (STATUS_LAT == 0) begin
            state_d[r] = EMPTY;
          end else begin
            guard_d[r] = GUARD_INIT;
            state_d[r] = GUARD;
          end
        end
        GUARD: begin
          // status_sblk is deliberately ignored here: it has not risen yet.
          if (guard_q[r] == '0) state_d[r] = EMPTY;
          else                  guard_d[r] = guard_q[r] - WID_GUARD'(1);
        end
        default: state_d[r] = EMPTY;
      endcase
    end
  end

  // Row FSM state, guard counters, issued data and status flags.
  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N_ROW; r++) begin
        state_q[r] <= EMPTY;
        guard_q[r] <= '0;
        data_q[r]  <= '0;
      end
      sched_idle_q    <= 1'b0;
      err_zero_mask_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      for (int r = 0; r < N_ROW; r++) begin
        state_q[r] <= state_d[r];
        guard_q[r] <= guard_d[r];
        if (state_q[r] == PEND && !bus.status_sblk[r]) data_q[r] <= hold_q[r];
      end
      sched_idle_q <= (&empty_vec) && (bus.status_sblk == '0);
      if (accept && (bus.inst_in_mask == '0)) err_zero_mask_q <= 1'b1;
    end
  end

  // Per-row instruction buffer, loaded on accept.
  // NOTE: the payload buffer has no reset; it is only read after a fresh
  // accept has written it, and the row FSM reset already drops its content.
  always_ff @(posedge clk_l) begin
    for (int r = 0; r < N_ROW; r++) begin
      if (accept && bus.inst_in_mask[r]) hold_q[r] <= bus.inst_in_data;
    end
  end

`ifdef SBLK_SCHED_PERF_EN
  logic [15:0]         issue_cnt_q [N_ROW];
  logic [15:0]         stall_cnt_q [N_ROW];
  logic [16*N_ROW-1:0] issue_flat;
  logic [16*N_ROW-1:0] stall_flat;

  // Issue counters wrap; stall counters saturate at all-ones.
  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N_ROW; r++) begin
        issue_cnt_q[r] <= '0;
        stall_cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < N_ROW; r++) begin
        if (state_q[r] == ISSUE) issue_cnt_q[r] <= issue_cnt_q[r] + 16'd1;
        if (state_q[r] == PEND && bus.status_sblk[r] && stall_cnt_q[r] != 16'hFFFF)
          stall_cnt_q[r] <= stall_cnt_q[r] + 16'd1;
      end
    end
  end

  // Flatten the counters onto the interface buses.
  always_comb begin
    issue_flat = '0;
    stall_flat = '0;
    for (int r = 0; r < N_ROW; r++) begin
      issue_flat[r*16 +: 16] = issue_cnt_q[r];
      stall_flat[r*16 +: 16] = stall_cnt_q[r];
    end
  end

  assign bus.issue_cnt = issue_flat;
  assign bus.stall_cnt = stall_flat;
`endif

endmodule

// File: tb/tb_sblk_row_inst_sched.sv
// Scoreboard bench for sblk_row_inst_sched (N_ROW=3, WID_INST=14, STATUS_LAT=2).
// Stimulus pushes expected (row, cycle, data) issues; a monitor on the falling
// edge pops and compares every inst_en pulse and checks inst_data stability.
module tb_sblk_row_inst_sched;

  localparam int NR = 3;
  localparam int WI = 14;

  typedef struct {
    int            row;
    int            cyc;
    logic [WI-1:0] data;
  } exp_t;

  logic clk_l = 1'b0;
  logic rst   = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [WI-1:0] last_data [NR];

  sblk_row_inst_sched_if #(.N_ROW(NR), .WID_INST(WI)) bus ();

  sblk_row_inst_sched #(.N_ROW(NR), .WID_INST(WI), .STATUS_LAT(2)) dut (
    .clk_l (clk_l),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_l = ~clk_l;
  always @(posedge clk_l) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int row, input int c, input logic [WI-1:0] d);
    exp_t e;
    e.row = row; e.cyc = c; e.data = d;
    exp_q.push_back(e);
  endtask

  // Offer one instruction; acc returns the cyc value right after the accepting edge.
  task automatic send(input logic [WI-1:0] d, input logic [NR-1:0] m, output int acc);
    int n;
    @(negedge clk_l);
    bus.inst_in_data = d;
    bus.inst_in_mask = m;
    bus.inst_in_vld  = 1'b1;
    acc = -1;
    n   = 0;
    while (acc < 0 && n < 50) begin
      #1;
      if (bus.inst_in_rdy) acc = cyc + 1;
      else begin
        @(negedge clk_l);
        n++;
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: data 0x%0h mask %b never accepted", d, m);
    end
    @(negedge clk_l);
    bus.inst_in_vld = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk_l) begin
    if (rst) begin
      for (int r = 0; r < NR; r++) last_data[r] = '0;
      check("en_in_rst", 64'(bus.inst_en), 64'd0);
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (bus.inst_en[r]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: row %0d cyc %0d data 0x%0h, none expected",
                     r, cyc, bus.inst_data[r*WI +: WI]);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("issue_row", 64'(r), 64'(e.row));
            check("issue_cyc", 64'(cyc), 64'(e.cyc));
            check("issue_data", 64'(bus.inst_data[r*WI +: WI]), 64'(e.data));
            last_data[r] = e.data;
          end
        end else begin
          check("data_hold", 64'(bus.inst_data[r*WI +: WI]), 64'(last_data[r]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    bus.inst_in_data = '0;
    bus.inst_in_mask = '0;
    bus.inst_in_vld  = 1'b0;
    bus.status_sblk  = '0;

    // Reset state.
    @(negedge clk_l);
    #1;
    check("rst_rdy", 64'(bus.inst_in_rdy), 64'd0);
    check("rst_idle", 64'(bus.sched_idle), 64'd0);
    check("rst_data", 64'(bus.inst_data), 64'd0);
    check("rst_err", 64'(bus.err_zero_mask), 64'd0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk_l);
    check("idle_after_rst", 64'(bus.sched_idle), 64'd1);
    check("rdy_after_rst", 64'(bus.inst_in_rdy), 64'd1);

    // Single issue to row 0.
    send(14'h1A5, 3'b001, a);
    push(0, a + 1, 14'h1A5);
    check("idle_busy", 64'(bus.sched_idle), 64'd1);  // cyc==a: registered, still old value
    @(negedge clk_l);
    check("idle_drop", 64'(bus.sched_idle), 64'd0);
    repeat (6) @(negedge clk_l);
    check("t1_done", 64'(exp_q.size()), 64'd0);
    check("t1_idle", 64'(bus.sched_idle), 64'd1);

    // Broadcast with row 1 busy.
    bus.status_sblk = 3'b010;
    send(14'h0F0, 3'b111, a);
    push(0, a + 1, 14'h0F0);
    push(2, a + 1, 14'h0F0);
    push(1, a + 5, 14'h0F0);
    repeat (4) @(negedge clk_l);
    bus.status_sblk = 3'b000;                 // cyc==a+4
    @(negedge clk_l);                         // cyc==a+5
    bus.inst_in_mask = 3'b001;
    #1 check("indep_rdy_row0", 64'(bus.inst_in_rdy), 64'd1);
    bus.inst_in_mask = 3'b010;
    #1 check("blocked_rdy_row1", 64'(bus.inst_in_rdy), 64'd0);
    bus.inst_in_mask = 3'b111;
    repeat (2) @(negedge clk_l);              // cyc==a+7, row 1 in GUARD
    #1 check("bcast_rdy_guard", 64'(bus.inst_in_rdy), 64'd0);
    @(negedge clk_l);                         // cyc==a+8
    #1 check("bcast_rdy_free", 64'(bus.inst_in_rdy), 64'd1);
    repeat (2) @(negedge clk_l);
    check("t2_done", 64'(exp_q.size()), 64'd0);

    // Back-to-back to row 1 with vld held; status toggles inside GUARD.
    @(negedge clk_l);
    bus.inst_in_data = 14'h2B1;
    bus.inst_in_mask = 3'b010;
    bus.inst_in_vld  = 1'b1;
    #1 check("b2b_rdy", 64'(bus.inst_in_rdy), 64'd1);
    a = cyc + 1;
    push(1, a + 1, 14'h2B1);
    push(1, a + 6, 14'h1C3);
    push(1, a + 11, 14'h0D2);
    while (cyc < a + 12) begin
      @(negedge clk_l);
      if (cyc == a)     bus.inst_in_data = 14'h1C3;
      if (cyc == a + 1) bus.status_sblk  = 3'b010;
      if (cyc == a + 2) begin #1 check("b2b_rdy_guard", 64'(bus.inst_in_rdy), 64'd0); end
      if (cyc == a + 3) bus.status_sblk  = 3'b000;
      if (cyc == a + 4) begin #1 check("b2b_rdy_empty", 64'(bus.inst_in_rdy), 64'd1); end
      if (cyc == a + 5) bus.inst_in_data = 14'h0D2;
      if (cyc == a + 10) bus.inst_in_vld = 1'b0;
    end
    repeat (4) @(negedge clk_l);
    check("t3_done", 64'(exp_q.size()), 64'd0);

    // Zero-mask accept.
    check("err_before", 64'(bus.err_zero_mask), 64'd0);
    send(14'h3FF, 3'b000, a);
    check("err_set", 64'(bus.err_zero_mask), 64'd1);
    repeat (5) @(negedge clk_l);
    check("err_sticky", 64'(bus.err_zero_mask), 64'd1);

    // Reset while row 2 is pending.
    bus.status_sblk = 3'b100;
    send(14'h155, 3'b100, a);
    repeat (2) @(negedge clk_l);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_en", 64'(bus.inst_en), 64'd0);
    check("mid_rst_data", 64'(bus.inst_data), 64'd0);
    check("mid_rst_rdy", 64'(bus.inst_in_rdy), 64'd0);
    check("mid_rst_idle", 64'(bus.sched_idle), 64'd0);
    check("mid_rst_err", 64'(bus.err_zero_mask), 64'd0);
    @(negedge clk_l);
    #2 rst = 1'b0;
    bus.status_sblk = 3'b000;
    repeat (10) @(negedge clk_l);
    check("t5_idle", 64'(bus.sched_idle), 64'd1);

`ifdef SBLK_SCHED_PERF_EN
    // Performance counters: 3 issues to row 0, 4 stalled PEND cycles.
    bus.status_sblk = 3'b001;
    send(14'h111, 3'b001, a);
    push(0, a + 5, 14'h111);
    repeat (4) @(negedge clk_l);
    bus.status_sblk = 3'b000;
    repeat (4) @(negedge clk_l);
    send(14'h222, 3'b001, a);
    push(0, a + 1, 14'h222);
    repeat (4) @(negedge clk_l);
    send(14'h333, 3'b001, a);
    push(0, a + 1, 14'h333);
    repeat (6) @(negedge clk_l);
    check("issue_cnt0", 64'(bus.issue_cnt[15:0]), 64'd3);
    check("stall_cnt0", 64'(bus.stall_cnt[15:0]), 64'd4);
    check("issue_cnt12", 64'(bus.issue_cnt[47:16]), 64'd0);
    check("stall_cnt12", 64'(bus.stall_cnt[47:16]), 64'd0);
`endif

    check("all_issued", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
